// File: rtl/it_pkg.sv
// Shared definitions for the IT input front-end: FSM state encodings and the
// default debounce length.
package it_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_DB     = 3'd1,
    PULSE        = 3'd2,
    RELEASE_WAIT = 3'd3,
    HALTED       = 3'd4
  } it_state_e;

  // Synchronised button level each state is waiting to see held stable.
  function automatic logic wait_lvl(it_state_e s);
    return (s == IDLE) || (s == PRESS_DB);
  endfunction

endpackage

// File: rtl/it_sync2.sv
// Parameterisable-width two-flop synchroniser with async active-low reset.
module it_sync2 #(
  parameter int W = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/it_input_ctrl.sv
// Push-button / switch-bank front-end for IT: synchronise, debounce, latch the
// switches on a confirmed press and emit one registered Enter pulse per press.
module it_input_ctrl
  import it_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Button,
  input  logic [7:0] Switches,
  input  logic       Halt,
  output logic       Enter,
  output logic [7:0] Input,
  output logic       Ready,
  output logic [7:0] EntryCount
);

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             btn_s;
  logic [7:0]       sw_s;
  it_state_e        state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  it_sync2 #(.W(1)) u_sync_btn (.Clock(Clock), .Reset(Reset), .d(Button),   .q(btn_s));
  it_sync2 #(.W(8)) u_sync_sw  (.Clock(Clock), .Reset(Reset), .d(Switches), .q(sw_s));

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:         if (Halt) nxt = HALTED;
                    else if (btn_s) nxt = PRESS_DB;
      PRESS_DB:     if (!btn_s) nxt = IDLE;
                    else if (Halt) nxt = HALTED;
                    else if (cnt == DB_MAX) nxt = PULSE;
      PULSE:        nxt = RELEASE_WAIT;
      RELEASE_WAIT: if (Halt) nxt = HALTED;
                    else if (!btn_s && cnt == DB_MAX) nxt = IDLE;
      HALTED:       if (!Halt && !btn_s && cnt == DB_MAX) nxt = IDLE;
      default:      nxt = IDLE;
    endcase
  end

  // Counter restarts whenever the awaited level flips, so a partial press count
  // can never be credited towards a release (and vice versa).
  always_comb begin
    cnt_nxt = '0;
    if (wait_lvl(nxt) == wait_lvl(state) && btn_s == wait_lvl(state))
      cnt_nxt = (cnt == DB_MAX) ? cnt : cnt + CNT_W'(1);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      Enter      <= 1'b0;
      Input      <= 8'h00;
      Ready      <= 1'b0;
      EntryCount <= 8'h00;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      Enter <= (nxt == PULSE);
      Ready <= (nxt == IDLE);
      if (nxt == PULSE) begin
        Input      <= sw_s;
        EntryCount <= EntryCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_it_input_ctrl.sv
// Self-checking bench for it_input_ctrl (DEBOUNCE_CYCLES=4): vector table of
// presses plus hand-written bounce, halt, reset and wrap sequences.
module tb_it_input_ctrl;

  logic       Clock = 1'b0;
  logic       Reset, Button, Halt;
  logic [7:0] Switches;
  logic       Enter, Ready;
  logic [7:0] Input, EntryCount;

  it_input_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .Button(Button), .Switches(Switches),
    .Halt(Halt), .Enter(Enter), .Input(Input), .Ready(Ready),
    .EntryCount(EntryCount)
  );

  always #5 Clock = ~Clock;

  typedef struct packed { logic [7:0] sw; logic [7:0] cnt; } exp_t;
  typedef struct { logic [7:0] sw; int hold; bit exp_en; } vec_t;

  exp_t       sb[$];
  int         checks = 0, errors = 0, enters = 0;
  logic [7:0] cnt_m = 8'h00, last_in = 8'h00;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  // Every observed Enter must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    exp_t e;
    if (Reset === 1'b1 && Enter === 1'b1) begin
      enters++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_enter: got Enter=1 Input=%0d expected no Enter", Input);
      end else begin
        e = sb.pop_front();
        chk("enter_input", Input, e.sw);
        chk("enter_count", EntryCount, e.cnt);
      end
    end
  end

  // Button high for 'hold' sampled edges; a press needs hold >= 5 to survive
  // two sync stages plus four stable samples before the PULSE edge.
  task automatic press(input logic [7:0] sw, input int hold, input bit exp_en);
    int first, e0;
    first = -1; e0 = enters;
    Switches = sw; Button = 1'b1;
    if (exp_en) begin cnt_m++; sb.push_back({sw, cnt_m}); end
    for (int i = 1; i <= hold + 12; i++) begin
      @(posedge Clock); #1;
      if (i == hold) Button = 1'b0;
      if (Enter && first < 0) first = i;
    end
    if (exp_en) last_in = sw;
    chk("press_latency", first, exp_en ? 7 : -1);
    chk("press_enters", enters - e0, exp_en ? 1 : 0);
    chk("press_input", Input, last_in);
    chk("press_ready", Ready, 1);
    chk("press_count", EntryCount, cnt_m);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    int   e0, first;
    vecs = '{'{8'hA5, 20, 1'b1}, '{8'h3C, 1, 1'b0}, '{8'hFF, 3, 1'b0},
             '{8'h11, 4, 1'b0},  '{8'h5A, 5, 1'b1}, '{8'h81, 30, 1'b1}};

    Reset = 1'b0; Button = 1'b0; Halt = 1'b0; Switches = 8'h00;
    tick(3);
    chk("rst_enter", Enter, 0);
    chk("rst_input", Input, 0);
    chk("rst_ready", Ready, 0);
    chk("rst_count", EntryCount, 0);
    Reset = 1'b1;
    chk("rst_rel_ready0", Ready, 0);
    tick(1);
    chk("rst_rel_ready1", Ready, 1);

    for (int v = 0; v < 6; v++) press(vecs[v].sw, vecs[v].hold, vecs[v].exp_en);

    // Bounce: 2-cycle toggles for 12 edges, then held; btn_s settles after edge 14.
    e0 = enters; first = -1;
    Switches = 8'hC3; Button = 1'b1; cnt_m++; sb.push_back({8'hC3, cnt_m});
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clock); #1;
      if (Enter && first < 0) first = i;
      if (i + 1 <= 12) Button = ((i / 2) % 2 == 0);
      else Button = (i + 1 <= 30);
    end
    last_in = 8'hC3;
    chk("bounce_latency", first, 19);
    chk("bounce_enters", enters - e0, 1);
    chk("bounce_ready", Ready, 1);

    // Halt blocks a press; the held press is not replayed after Halt drops.
    Halt = 1'b1; tick(2);
    chk("halt_ready", Ready, 0);
    e0 = enters; Switches = 8'h3C; Button = 1'b1; tick(20);
    chk("halt_enters", enters - e0, 0);
    chk("halt_input", Input, last_in);
    Halt = 1'b0; tick(10);
    chk("halt_held_enters", enters - e0, 0);
    chk("halt_held_ready", Ready, 0);
    Button = 1'b0; tick(10);
    chk("halt_rel_ready", Ready, 1);
    chk("halt_rel_enters", enters - e0, 0);
    press(8'h3C, 8, 1'b1);

    // Halt raised during the pulse cycle: pulse still completes, then HALTED.
    e0 = enters; Switches = 8'h77; Button = 1'b1;
    cnt_m++; sb.push_back({8'h77, cnt_m});
    tick(7);
    chk("hp_enter", Enter, 1);
    Halt = 1'b1; tick(3);
    chk("hp_ready", Ready, 0);
    chk("hp_enters", enters - e0, 1);
    Halt = 1'b0; Button = 1'b0; tick(10);
    last_in = 8'h77;
    chk("hp_ready_back", Ready, 1);
    chk("hp_input", Input, 8'h77);

    // Reset lands on the Enter cycle: everything drops at once.
    Switches = 8'h99; Button = 1'b1; tick(7);
    chk("mr_pre_enter", Enter, 1);
    Reset = 1'b0; #1;
    chk("mr_enter", Enter, 0);
    chk("mr_input", Input, 0);
    chk("mr_ready", Ready, 0);
    chk("mr_count", EntryCount, 0);
    sb.delete(); cnt_m = 8'h00; last_in = 8'h00; Button = 1'b0;
    tick(2);
    Reset = 1'b1;
    chk("mr_rel_ready0", Ready, 0);
    tick(1);
    chk("mr_rel_ready1", Ready, 1);
    chk("mr_rel_count", EntryCount, 0);

    // 256 presses wrap the entry counter back to zero.
    e0 = enters;
    for (int k = 0; k < 256; k++) press(8'(k), 5, 1'b1);
    chk("wrap_count", EntryCount, 0);
    chk("wrap_enters", enters - e0, 256);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
